// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART frame transmitter: frame bit
//               values, frame geometry, default baud divider and the state
//               encodings of the block FSM and the byte serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 50 MHz system clock, 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // 8N1 frame geometry
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = 10;

    // Block-level FSM states
    localparam logic [2:0] FSM_IDLE = 3'd0;
    localparam logic [2:0] FSM_LOAD = 3'd1;
    localparam logic [2:0] FSM_SEND = 3'd2;
    localparam logic [2:0] FSM_NEXT = 3'd3;
    localparam logic [2:0] FSM_DONE = 3'd4;

    // Byte serializer states
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Single-byte 8N1 UART serializer. A one-cycle tx_dv latches
//               tx_byte and sends start bit, 8 data bits LSB first and a stop
//               bit, each CLKS_PER_BIT cycles long. tx_done pulses during the
//               last cycle of the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_dv,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       tx_active,
    output logic       tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(CLKS_PER_BIT - 1);
    // tx_done is registered, so it is raised one count early to land on
    // the final stop-bit cycle
    localparam logic [CNT_W-1:0] c_done_cnt = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [2:0]       c_last_bit = 3'(DATA_BITS - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_data;
    logic             r_tx;
    logic             r_done;

    // Frame sequencer: walks start, data and stop bits with a per-bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_tx    <= STOP_BIT;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                    if (tx_dv) begin
                        r_data  <= tx_byte;
                        r_tx    <= START_BIT;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_cnt == c_last_cnt) begin
                        r_cnt   <= '0;
                        r_tx    <= r_data[0];
                        r_state <= TX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (r_cnt == c_last_cnt) begin
                        r_cnt <= '0;
                        if (r_bit == c_last_bit) begin
                            r_tx    <= STOP_BIT;
                            r_state <= TX_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_data[r_bit + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (r_cnt == c_done_cnt) begin
                        r_done <= 1'b1;
                    end
                    if (r_cnt == c_last_cnt) begin
                        r_cnt   <= '0;
                        r_state <= TX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign tx        = r_tx;
    assign tx_active = (r_state != TX_IDLE);
    assign tx_done   = r_done;

endmodule
`default_nettype wire

// File: rtl/uart_frame_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_transmitter
// Description : Holds a NUM_ELEMENTS-byte result buffer written by the core
//               and, on start, sends the whole buffer byte 0 first as 8N1
//               UART frames. busy covers the transfer, done pulses once at
//               the end.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_transmitter
    import uart_pkg::*;
#(
    parameter int NUM_ELEMENTS = 4,
    parameter int ADDR_W       = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_ELEMENTS - 1);

    // Sized to a power of two so every index value maps to real storage
    logic [7:0]       r_mem [0:(1 << IDX_W) - 1];
    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_tx_dv;
    logic [7:0]       r_tx_byte;

    logic             w_wr_ok;
    logic             w_tx_active;
    logic             w_tx_done;

    assign w_wr_ok = wr_en && !r_busy && (32'(wr_addr) < NUM_ELEMENTS);

    // Buffer write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Block FSM: feed one byte at a time to the serializer until the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FSM_IDLE;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
        end else begin
            r_tx_dv <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                FSM_IDLE: begin
                    r_busy <= 1'b0;
                    if (start) begin
                        r_idx   <= '0;
                        r_state <= FSM_LOAD;
                    end
                end
                FSM_LOAD: begin
                    r_busy <= 1'b1;
                    // Serializer is always back in idle here; the guard only
                    // protects against handing it a byte mid-frame
                    if (!w_tx_active) begin
                        r_tx_byte <= r_mem[r_idx];
                        r_tx_dv   <= 1'b1;
                        r_state   <= FSM_SEND;
                    end
                end
                FSM_SEND: begin
                    if (w_tx_done) begin
                        r_state <= FSM_NEXT;
                    end
                end
                FSM_NEXT: begin
                    if (r_idx == c_last_idx) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FSM_DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= FSM_LOAD;
                    end
                end
                FSM_DONE: begin
                    r_state <= FSM_IDLE;
                end
                default: r_state <= FSM_IDLE;
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk       (clk),
        .rst       (rst),
        .tx_dv     (r_tx_dv),
        .tx_byte   (r_tx_byte),
        .tx        (tx),
        .tx_active (w_tx_active),
        .tx_done   (w_tx_done)
    );

    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_transmitter
// Description : Directed self-checking bench. Instance A: 4 bytes, 4 clk/bit.
//               Instance B: 1 byte, 2 clk/bit. A line decoder samples tx on
//               falling clock edges and checks bytes and frame timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_transmitter;

    logic       clk;
    logic       rst;
    logic       start_a, wr_en_a, start_b, wr_en_b;
    logic [7:0] wr_addr_a, wr_data_a, wr_addr_b, wr_data_b;
    logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;

    int cyc = 0;
    int done_cnt [2] = '{0, 0};
    int done_cyc [2] = '{0, 0};
    int n_pass = 0;
    int n_total = 0;

    uart_frame_transmitter #(.NUM_ELEMENTS(4), .ADDR_W(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .wr_en(wr_en_a),
        .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    uart_frame_transmitter #(.NUM_ELEMENTS(1), .ADDR_W(8), .CLKS_PER_BIT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .wr_en(wr_en_b),
        .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_a) begin
            done_cnt[0] = done_cnt[0] + 1;
            done_cyc[0] = cyc;
        end
        if (done_b) begin
            done_cnt[1] = done_cnt[1] + 1;
            done_cyc[1] = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    endtask

    function automatic logic cur_tx(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    task automatic drive(input bit sel, input logic st, input logic we,
                         input logic [7:0] a, input logic [7:0] d);
        if (sel) begin
            start_b = st; wr_en_b = we; wr_addr_b = a; wr_data_b = d;
        end else begin
            start_a = st; wr_en_a = we; wr_addr_a = a; wr_data_a = d;
        end
    endtask

    task automatic wr(input bit sel, input logic [7:0] a, input logic [7:0] d);
        drive(sel, 1'b0, 1'b1, a, d);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic wait_fall(input bit sel, output int fc, output bit ok);
        ok = 1'b0;
        fc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cur_tx(sel) === 1'b0) begin
                ok = 1'b1;
                fc = cyc;
                break;
            end
        end
    endtask

    // Entered on the first start-bit cycle; leaves on the last stop-bit cycle
    task automatic rx_frame(input bit sel, input int cpb, input bit inject,
                            output logic [7:0] b, output bit ok);
        logic [9:0] bits;
        logic       v;
        ok = 1'b1;
        bits = '0;
        for (int i = 0; i < 10 * cpb; i++) begin
            if (i > 0) @(negedge clk);
            if (inject && i == 5) drive(sel, 1'b1, 1'b1, 8'd1, 8'h11);
            if (inject && i == 6) drive(sel, 1'b0, 1'b0, 8'h00, 8'h00);
            v = cur_tx(sel);
            if (i % cpb == 0) bits[i / cpb] = v;
            else if (v !== bits[i / cpb]) ok = 1'b0;
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
        b = bits[8:1];
    endtask

    task automatic run_block(input bit sel, input int n, input int cpb,
                             input logic [31:0] exp, input bit known,
                             input bit inject, input bit wr0);
        int         s, fc, last_end, d0;
        bit         ok, seen;
        logic [7:0] b;
        d0 = done_cnt[sel];
        s  = cyc;
        if (wr0) drive(sel, 1'b1, 1'b1, 8'd0, 8'h55);
        else     drive(sel, 1'b1, 1'b0, 8'd0, 8'h00);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("busy_not_yet", 32'(cur_busy(sel)), 32'd0);
        @(negedge clk);
        chk("busy_set", 32'(cur_busy(sel)), 32'd1);
        last_end = 0;
        for (int k = 0; k < n; k++) begin
            wait_fall(sel, fc, ok);
            chk("frame_start_seen", 32'(ok), 32'd1);
            if (k == 0) chk("start_to_tx_fall", 32'(fc - s), 32'd3);
            else        chk("inter_frame_gap", 32'(fc - last_end), 32'd4);
            rx_frame(sel, cpb, inject && (k == 1), b, ok);
            chk("frame_shape", 32'(ok), 32'd1);
            if (known) chk($sformatf("byte%0d", k), 32'(b), 32'(exp[8*k +: 8]));
            else       chk("byte_no_x", 32'($isunknown(b)), 32'd0);
            last_end = cyc;
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", 32'(done_cnt[sel] - d0), 32'd1);
        chk("done_delay", 32'(done_cyc[sel] - last_end), 32'd2);
        chk("busy_cleared", 32'(cur_busy(sel)), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (cur_tx(sel) !== 1'b1 || cur_busy(sel) !== 1'b0) seen = 1'b1;
        end
        chk("quiet_after_done", 32'(seen), 32'd0);
    endtask

    initial begin
        int  fc, d0;
        bit  ok, seen;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", 32'(tx_a), 32'd1);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_done", 32'(done_a), 32'd0);
        chk("reset_tx_b", 32'(tx_b), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Unwritten buffer: frames still well-formed, no X on the line
        run_block(1'b0, 4, 4, 32'h0, 1'b0, 1'b0, 1'b0);

        wr(1'b0, 8'd0, 8'hA5);
        wr(1'b0, 8'd1, 8'h3C);
        wr(1'b0, 8'd2, 8'hFF);
        wr(1'b0, 8'd3, 8'h00);
        run_block(1'b0, 4, 4, 32'h00FF3CA5, 1'b1, 1'b0, 1'b0);

        // start + write during frame 1 are both dropped
        run_block(1'b0, 4, 4, 32'h00FF3CA5, 1'b1, 1'b1, 1'b0);
        run_block(1'b0, 4, 4, 32'h00FF3CA5, 1'b1, 1'b0, 1'b0);

        // Reset during data bit 3 of the first frame
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_fall(1'b0, fc, ok);
        chk("abort_frame_seen", 32'(ok), 32'd1);
        repeat (17) @(negedge clk);
        chk("abort_busy_before", 32'(busy_a), 32'd1);
        d0 = done_cnt[0];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_tx_high", 32'(tx_a), 32'd1);
        chk("abort_busy_low", 32'(busy_a), 32'd0);
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx_a !== 1'b1) seen = 1'b1;
        end
        chk("abort_line_idle", 32'(seen), 32'd0);
        chk("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
        run_block(1'b0, 4, 4, 32'h00FF3CA5, 1'b1, 1'b0, 1'b0);

        // Out-of-range write ignored; write coinciding with start lands first
        wr(1'b0, 8'd4, 8'h77);
        run_block(1'b0, 4, 4, 32'h00FF3CA5, 1'b1, 1'b0, 1'b0);
        run_block(1'b0, 4, 4, 32'h00FF3C55, 1'b1, 1'b0, 1'b1);

        // Single-element buffer, 2 clk/bit
        wr(1'b1, 8'd0, 8'h81);
        run_block(1'b1, 1, 2, 32'h00000081, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
